idex_stage_reg: RTL and testbench
=================================

# idex_stage_reg

Parametrised ID/EX pipeline stage register with a valid/ready handshake, per-source operand-hazard interlock, flush, and a saturating bubble counter. Sits between the decode stage and the ALU. Generalises the fixed two-source ID/EX register to N sources, configurable widths, per-source immediate selection and downstream back-pressure. Inserts NOP bubbles while any used source operand is still being modified in flight.

## Interface
- DATA_W, 32, operand/immediate width
- REG_W, 5, destination register index width
- ALU_W, 4, ALU opcode width
- NUM_SRC, 2, number of source operands (1..4)
- NOP_CODE, 0, ALU opcode emitted for bubbles/reset
- CNT_W, 16, bubble counter width

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage accepts the ID instruction this cycle (combinational)
- in_alu_type  in  ALU_W  opcode
- in_imm  in  DATA_W  immediate
- in_src  in  NUM_SRC*DATA_W  source operands; source k at bits [k*DATA_W +: DATA_W]
- in_src_use  in  NUM_SRC  source k is read by this instruction
- in_src_imm  in  NUM_SRC  source k takes in_imm instead of in_src[k]
- in_src_busy  in  NUM_SRC  source k's register is being modified by an in-flight instruction
- in_rd  in  REG_W  destination register
- in_wr_en  in  1  writes ALU result to in_rd
- flush  in  1  kill the ID instruction and the held EX instruction
- out_valid  out  1  EX payload valid
- out_ready  in  1  EX can take the payload
- out_alu_type  out  ALU_W
- out_src  out  NUM_SRC*DATA_W
- out_rd  out  REG_W
- out_wr_en  out  1
- block  out  1  stall request back to IF/ID: in_valid && !in_ready
- bubble_cnt  out  CNT_W  bubbles inserted since reset/clear
- cnt_clear  in  1  synchronous clear of bubble_cnt

## Operation
- hazard = OR over k of (in_src_use[k] && !in_src_imm[k] && in_src_busy[k]). An immediate-selected source never causes a hazard.
- load = !out_valid || out_ready. The output register may change only when load=1.
- in_ready = load && !hazard && !flush.
- accept = in_valid && in_ready. On accept, the register captures:
  - alu_type, rd and wr_en from the inputs.
  - out_src[k] = in_src_imm[k] ? in_imm : in_src[k].
  - out_valid is set to 1.
- Bubble: load && in_valid && hazard && !flush.
  - Register gets out_valid=0, alu_type=NOP_CODE, wr_en=0, rd=0, out_src=0.
  - bubble_cnt increments and saturates at all-ones.
- load && !in_valid && !flush: out_valid=0. Payload fields are not required to change; the bench checks only valid-qualified payload.
- !load && !flush (EX stalled): register holds and in_ready=0. No bubble is counted because the stall is EX back-pressure, not a hazard.
- flush=1: the register is cleared to the bubble values regardless of out_ready. The ID instruction is not accepted and no bubble is counted. flush has priority over every other event.
- cnt_clear=1: bubble_cnt becomes 0 next cycle. It has priority over an increment in the same cycle.
- in_src_use/in_src_imm/in_src_busy bits above NUM_SRC do not exist; no other hazard source exists.

## Timing
- Reset (rst=0, async): out_valid=0, out_alu_type=NOP_CODE, out_src=0, out_rd=0, out_wr_en=0, bubble_cnt=0. Outputs are combinational from registers and inputs: in_ready=0 while out_valid=0 only if hazard or flush, so in_ready = !hazard && !flush after reset; block follows.
- Reset release mid-operation: first accept can occur on the first rising edge with rst=1.
- Latency: an instruction accepted at edge n appears on out_* after edge n; one cycle, no skid buffer.
- Throughput: one instruction per cycle while out_ready=1 and no hazard.
- Hazard lasting H cycles with in_valid held: exactly H bubbles and H bubble_cnt increments. The instruction is accepted in the first cycle hazard=0.
- ID must hold all in_* stable while in_valid && !in_ready.
- Simultaneous out_ready=0 and hazard: hold, no bubble, no count. If out_valid=0, a bubble is still counted because load=1.

## Test plan
- Reset mid-stream: drive rst=0 while out_valid=1, alu_type=3 -> outputs immediately NOP_CODE/0, bubble_cnt=0. After release, in_valid with src={5,7} -> out_src={5,7}, out_valid=1 one cycle later.
- Immediate select: in_src_imm=2'b10, in_imm=0x100, in_src={1,2}, in_src_busy=2'b10 -> no hazard, out_src={1,0x100}, bubble_cnt unchanged.
- Hazard: in_src_use=2'b01, in_src_busy[0]=1 for 3 cycles then 0 -> 3 bubbles (out_valid=0, out_wr_en=0), block=1 for 3 cycles, bubble_cnt=3, instruction emitted on cycle 4.
- Back-pressure: out_valid=1, out_ready=0 for 2 cycles with a new in_valid -> payload held, in_ready=0, block=1, bubble_cnt unchanged; accepts once out_ready=1.
- Flush vs stall: flush=1 while out_ready=0, out_valid=1 and hazard=1 -> next cycle out_valid=0, alu_type=NOP_CODE, bubble_cnt unchanged.
- Counter saturation/clear with CNT_W=2: 5 hazard cycles -> bubble_cnt=3. cnt_clear together with a bubble -> 0.

Source files
------------

// File: rtl/idex_stage_reg_if.sv
// ID/EX stage bus: the decode-side request with its operands and hazard
// flags, plus the execute-side payload with its valid/ready handshake.
// The master drives the ID request and EX ready; the slave is the stage.
interface idex_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALU_W   = 4,
  parameter int NUM_SRC = 2
);
  // ID side
  logic                      in_valid;
  logic                      in_ready;
  logic [ALU_W-1:0]          in_alu_type;
  logic [DATA_W-1:0]         in_imm;
  logic [NUM_SRC*DATA_W-1:0] in_src;
  logic [NUM_SRC-1:0]        in_src_use;
  logic [NUM_SRC-1:0]        in_src_imm;
  logic [NUM_SRC-1:0]        in_src_busy;
  logic [REG_W-1:0]          in_rd;
  logic                      in_wr_en;
  // EX side
  logic                      out_valid;
  logic                      out_ready;
  logic [ALU_W-1:0]          out_alu_type;
  logic [NUM_SRC*DATA_W-1:0] out_src;
  logic [REG_W-1:0]          out_rd;
  logic                      out_wr_en;

  modport master (
    output in_valid, in_alu_type, in_imm, in_src, in_src_use, in_src_imm,
           in_src_busy, in_rd, in_wr_en, out_ready,
    input  in_ready, out_valid, out_alu_type, out_src, out_rd, out_wr_en
  );

  modport slave (
    input  in_valid, in_alu_type, in_imm, in_src, in_src_use, in_src_imm,
           in_src_busy, in_rd, in_wr_en, out_ready,
    output in_ready, out_valid, out_alu_type, out_src, out_rd, out_wr_en
  );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline stage register. Accepts one decoded instruction per cycle,
// inserts NOP bubbles while a used register source is still in flight,
// holds under EX back-pressure, and counts inserted bubbles (saturating).
module idex_stage_reg #(
  parameter int               DATA_W   = 32,
  parameter int               REG_W    = 5,
  parameter int               ALU_W    = 4,
  parameter int               NUM_SRC  = 2,
  parameter logic [ALU_W-1:0] NOP_CODE = {ALU_W{1'b0}},
  parameter int               CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  idex_stage_reg_if.slave      bus,
  input  logic                 flush,
  input  logic                 cnt_clear,
  output logic                 block,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam int SRC_W = NUM_SRC * DATA_W;

  logic                 hazard_s;
  logic                 load_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 bubble_s;
  logic [SRC_W-1:0]     sel_src_s;

  logic                 out_valid_d,    out_valid_q;
  logic [ALU_W-1:0]     out_alu_type_d, out_alu_type_q;
  logic [SRC_W-1:0]     out_src_d,      out_src_q;
  logic [REG_W-1:0]     out_rd_d,       out_rd_q;
  logic                 out_wr_en_d,    out_wr_en_q;
  logic [CNT_W-1:0]     bubble_cnt_d,   bubble_cnt_q;

  // Handshake decode: a register source that is read, not replaced by the
  // immediate, and still being written by an older instruction is a hazard.
  always_comb begin
    hazard_s   = |(bus.in_src_use & ~bus.in_src_imm & bus.in_src_busy);
    load_s     = !out_valid_q || bus.out_ready;
    in_ready_s = load_s && !hazard_s && !flush;
    accept_s   = bus.in_valid && in_ready_s;
    bubble_s   = load_s && bus.in_valid && hazard_s && !flush;
  end

  // Per-source operand selection between register value and immediate.
  always_comb begin
    sel_src_s = {SRC_W{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.in_src_imm[k]) begin
        sel_src_s[k*DATA_W +: DATA_W] = bus.in_imm;
      end else begin
        sel_src_s[k*DATA_W +: DATA_W] = bus.in_src[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next payload: flush beats everything, then accept, then bubble; an idle
  // load only drops valid, and an EX stall holds the register unchanged.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_alu_type_d = out_alu_type_q;
    out_src_d      = out_src_q;
    out_rd_d       = out_rd_q;
    out_wr_en_d    = out_wr_en_q;
    if (flush || bubble_s) begin
      out_valid_d    = 1'b0;
      out_alu_type_d = NOP_CODE;
      out_src_d      = {SRC_W{1'b0}};
      out_rd_d       = {REG_W{1'b0}};
      out_wr_en_d    = 1'b0;
    end else if (accept_s) begin
      out_valid_d    = 1'b1;
      out_alu_type_d = bus.in_alu_type;
      out_src_d      = sel_src_s;
      out_rd_d       = bus.in_rd;
      out_wr_en_d    = bus.in_wr_en;
    end else if (load_s) begin
      out_valid_d    = 1'b0;
    end else begin
      out_valid_d    = out_valid_q;
    end
  end

  // Bubble counter: clear wins over increment; increment saturates.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clear) begin
      bubble_cnt_d = {CNT_W{1'b0}};
    end else if (bubble_s && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Stage register and bubble counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q    <= 1'b0;
      out_alu_type_q <= NOP_CODE;
      out_src_q      <= {SRC_W{1'b0}};
      out_rd_q       <= {REG_W{1'b0}};
      out_wr_en_q    <= 1'b0;
      bubble_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      out_valid_q    <= out_valid_d;
      out_alu_type_q <= out_alu_type_d;
      out_src_q      <= out_src_d;
      out_rd_q       <= out_rd_d;
      out_wr_en_q    <= out_wr_en_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_alu_type = out_alu_type_q;
  assign bus.out_src      = out_src_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_wr_en    = out_wr_en_q;
  assign block            = bus.in_valid && !in_ready_s;
  assign bubble_cnt       = bubble_cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg with NOP_CODE=4'hF and a 2-bit bubble
// counter so that NOP insertion and saturation are directly visible.
module tb_idex_stage_reg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALU_W   = 4;
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 2;
  localparam logic [ALU_W-1:0] NOP = 4'hF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             cnt_clear = 1'b0;
  logic             block;
  logic [CNT_W-1:0] bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  idex_stage_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .ALU_W(ALU_W), .NUM_SRC(NUM_SRC)) bus ();

  idex_stage_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ALU_W(ALU_W), .NUM_SRC(NUM_SRC),
    .NOP_CODE(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .cnt_clear(cnt_clear), .block(block), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] alu, input logic [31:0] s1,
                       input logic [31:0] s0, input logic [1:0] use_m, input logic [1:0] imm_m,
                       input logic [1:0] busy_m, input logic [4:0] rd, input logic wr,
                       input logic [31:0] imm);
    bus.in_valid    = v;
    bus.in_alu_type = alu;
    bus.in_src      = {s1, s0};
    bus.in_src_use  = use_m;
    bus.in_src_imm  = imm_m;
    bus.in_src_busy = busy_m;
    bus.in_rd       = rd;
    bus.in_wr_en    = wr;
    bus.in_imm      = imm;
  endtask

  initial begin
    drive(1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 32'h0);
    bus.out_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    // reset state
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_alu", 64'(bus.out_alu_type), 64'(NOP));
    check_eq("rst_src", bus.out_src, 64'd0);
    check_eq("rst_rd_wr", {bus.out_rd, bus.out_wr_en}, 64'd0);
    check_eq("rst_cnt", 64'(bubble_cnt), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst = 1'b1;

    // basic accept, one-cycle latency
    drive(1'b1, 4'd3, 32'd7, 32'd5, 2'b11, 2'b00, 2'b00, 5'd9, 1'b1, 32'h0);
    #1;
    check_eq("acc_ready", {bus.in_ready, block}, 64'b10);
    step();
    check_eq("acc_valid", 64'(bus.out_valid), 64'd1);
    check_eq("acc_alu", 64'(bus.out_alu_type), 64'd3);
    check_eq("acc_src", bus.out_src, {32'd7, 32'd5});
    check_eq("acc_rd_wr", {bus.out_rd, bus.out_wr_en}, {5'd9, 1'b1});

    // reset mid-stream clears outputs immediately
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_alu", 64'(bus.out_alu_type), 64'(NOP));
    check_eq("mid_rst_src", bus.out_src, 64'd0);
    rst = 1'b1;
    drive(1'b1, 4'd2, 32'd7, 32'd5, 2'b11, 2'b00, 2'b00, 5'd1, 1'b1, 32'h0);
    step();
    check_eq("post_rst_src", bus.out_src, {32'd7, 32'd5});
    check_eq("post_rst_valid", 64'(bus.out_valid), 64'd1);

    // back-to-back throughput; unused busy source is not a hazard
    drive(1'b1, 4'd5, 32'd3, 32'd4, 2'b01, 2'b00, 2'b10, 5'd2, 1'b0, 32'h0);
    #1;
    check_eq("unused_busy_ready", 64'(bus.in_ready), 64'd1);
    step();
    check_eq("thru_alu", 64'(bus.out_alu_type), 64'd5);
    check_eq("thru_src", bus.out_src, {32'd3, 32'd4});

    // immediate select masks busy
    drive(1'b1, 4'd1, 32'd2, 32'd1, 2'b11, 2'b10, 2'b10, 5'd3, 1'b1, 32'h100);
    #1;
    check_eq("imm_ready", 64'(bus.in_ready), 64'd1);
    step();
    check_eq("imm_src", bus.out_src, {32'h100, 32'd1});
    check_eq("imm_cnt", 64'(bubble_cnt), 64'd0);

    // hazard for three cycles
    drive(1'b1, 4'd6, 32'd0, 32'h11, 2'b01, 2'b00, 2'b01, 5'd4, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("haz_block", {bus.in_ready, block}, 64'b01);
      step();
      check_eq("haz_bubble", {bus.out_valid, bus.out_wr_en, bus.out_alu_type}, {2'b00, NOP});
      check_eq("haz_cnt", 64'(bubble_cnt), 64'(i + 1));
    end
    bus.in_src_busy = 2'b00;
    cnt_clear = 1'b1;
    #1;
    check_eq("haz_release_ready", 64'(bus.in_ready), 64'd1);
    step();
    cnt_clear = 1'b0;
    check_eq("haz_emit", {bus.out_valid, bus.out_alu_type}, {1'b1, 4'd6});
    check_eq("haz_emit_src", bus.out_src, {32'd0, 32'h11});
    check_eq("clr_on_accept", 64'(bubble_cnt), 64'd0);

    // EX back-pressure: hold, no counting even with a hazard
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd7, 32'h22, 32'h33, 2'b11, 2'b00, 2'b00, 5'd5, 1'b1, 32'h0);
    #1;
    check_eq("bp_block", {bus.in_ready, block}, 64'b01);
    step();
    check_eq("bp_hold1", {bus.out_valid, bus.out_alu_type}, {1'b1, 4'd6});
    bus.in_src_busy = 2'b01;
    step();
    check_eq("bp_hold2", {bus.out_valid, bus.out_alu_type}, {1'b1, 4'd6});
    check_eq("bp_cnt", 64'(bubble_cnt), 64'd0);
    bus.in_src_busy = 2'b00;
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(bus.in_ready), 64'd1);
    step();
    check_eq("bp_accept", {bus.out_valid, bus.out_alu_type}, {1'b1, 4'd7});
    check_eq("bp_accept_src", bus.out_src, {32'h22, 32'h33});

    // flush during stall and hazard
    bus.out_ready = 1'b0;
    bus.in_src_busy = 2'b01;
    flush = 1'b1;
    #1;
    check_eq("flush_block", {bus.in_ready, block}, 64'b01);
    step();
    flush = 1'b0;
    check_eq("flush_out", {bus.out_valid, bus.out_wr_en, bus.out_alu_type, bus.out_rd}, {2'b00, NOP, 5'd0});
    check_eq("flush_src", bus.out_src, 64'd0);
    check_eq("flush_cnt", 64'(bubble_cnt), 64'd0);

    // idle load drops valid
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd8, 32'd1, 32'd2, 2'b11, 2'b00, 2'b00, 5'd6, 1'b1, 32'h0);
    step();
    check_eq("idle_pre", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    step();
    check_eq("idle_valid", 64'(bus.out_valid), 64'd0);

    // saturation with out_ready=0 while empty; clear beats increment
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd9, 32'd0, 32'd0, 2'b01, 2'b00, 2'b01, 5'd7, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("sat_cnt", 64'(bubble_cnt), 64'((i < 3) ? (i + 1) : 3));
    end
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    check_eq("clr_vs_bubble", 64'(bubble_cnt), 64'd0);
    step();
    check_eq("cnt_after_clr", 64'(bubble_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
